// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM duty scheduler.
package pwm_pkg;

  localparam int unsigned DUTY_W        = 4;
  localparam int unsigned PERIOD_CYCLES = 256;
  localparam int unsigned PHASE_W       = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StRamping = 2'd2
  } sched_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Move cur toward tgt by at most step; step of zero jumps straight to tgt.
  // Done one bit wider so the sum/difference can never wrap.
  function automatic logic [DUTY_W-1:0] ramp_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt,
                                                    input logic [DUTY_W:0]   step);
    logic [DUTY_W:0] c;
    logic [DUTY_W:0] t;
    logic [DUTY_W:0] nxt;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (step == '0) begin
      nxt = t;
    end else if (t > c) begin
      nxt = ((t - c) > step) ? (c + step) : t;
    end else begin
      nxt = ((c - t) > step) ? (c - step) : t;
    end
    return DUTY_W'(nxt);
  endfunction

endpackage

// File: rtl/pwm_duty_scheduler_if.sv
// Request/ack and duty output bundle between the requesters and the scheduler.
interface pwm_duty_scheduler_if;
  import pwm_pkg::*;

  logic              req_a;
  logic [DUTY_W-1:0] duty_a;
  logic              req_b;
  logic [DUTY_W-1:0] duty_b;
  logic              ack_a;
  logic              ack_b;
  logic [DUTY_W-1:0] duty_cycle;
  logic              period_start;
  logic              busy;

  // Requester side.
  modport master (
    output req_a, duty_a, req_b, duty_b,
    input  ack_a, ack_b, duty_cycle, period_start, busy
  );

  // Scheduler side.
  modport slave (
    input  req_a, duty_a, req_b, duty_b,
    output ack_a, ack_b, duty_cycle, period_start, busy
  );

endinterface

// File: rtl/pwm_req_arbiter.sv
// Two-way round-robin arbiter feeding a single-entry pending slot, with
// registered one-cycle ack pulses back to the requesters.
module pwm_req_arbiter
  import pwm_pkg::*;
(
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              req_a,
  input  logic [DUTY_W-1:0] duty_a,
  input  logic              req_b,
  input  logic [DUTY_W-1:0] duty_b,
  input  logic              consume,
  output logic              grant,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DUTY_W-1:0] pending,
  output logic              pending_v
);

  req_id_e last_grant_q;
  logic    grant_a;
  logic    grant_b;

  // Grant only into an empty slot; a tie goes to whoever did not win last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!pending_v) begin
      if (req_a && req_b) begin
        if (last_grant_q == REQ_B) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

  assign grant = grant_a | grant_b;

  // Slot fill/drain and ack pulses; fill and drain never coincide since
  // a grant needs the slot empty and a drain needs it full.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      pending      <= '0;
      pending_v    <= 1'b0;
      last_grant_q <= REQ_B;
    end else begin
      ack_a <= grant_a;
      ack_b <= grant_b;
      if (consume && pending_v) begin
        pending_v <= 1'b0;
      end else if (grant) begin
        pending_v    <= 1'b1;
        pending      <= grant_a ? duty_a : duty_b;
        last_grant_q <= grant_a ? REQ_A : REQ_B;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// Schedules duty-cycle updates from two requesters onto PWM period
// boundaries, optionally slew-limiting each step.
module pwm_duty_scheduler
  import pwm_pkg::*;
#(
  parameter int unsigned       RAMP_STEP  = 1,
  parameter logic [DUTY_W-1:0] RESET_DUTY = '0
) (
  input logic                 clk_50M,
  input logic                 reset,
  pwm_duty_scheduler_if.slave bus
);

  localparam int unsigned DutyMax  = (1 << DUTY_W) - 1;
  localparam int unsigned StepSat  = (RAMP_STEP > DutyMax) ? DutyMax : RAMP_STEP;
  localparam int unsigned DutyExtW = DUTY_W + 1;
  localparam logic [DUTY_W:0] Step = DutyExtW'(StepSat);
  localparam logic [PHASE_W-1:0] LastPhase = PHASE_W'(PERIOD_CYCLES - 1);

  logic [PHASE_W-1:0] phase_cnt_q;
  logic               boundary;
  logic               grant;
  logic [DUTY_W-1:0]  pending;
  logic               pending_v;
  logic [DUTY_W-1:0]  target_q;
  logic [DUTY_W-1:0]  target_new;
  logic [DUTY_W-1:0]  duty_q;
  logic [DUTY_W-1:0]  duty_next;
  logic               busy_q;
  sched_state_e       state_q;
  sched_state_e       state_d;

  pwm_req_arbiter u_arbiter (
    .clk_50M   (clk_50M),
    .reset     (reset),
    .req_a     (bus.req_a),
    .duty_a    (bus.duty_a),
    .req_b     (bus.req_b),
    .duty_b    (bus.duty_b),
    .consume   (boundary),
    .grant     (grant),
    .ack_a     (bus.ack_a),
    .ack_b     (bus.ack_b),
    .pending   (pending),
    .pending_v (pending_v)
  );

  // Free-running period phase, kept in step with the PWM block's own counter.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      phase_cnt_q <= '0;
    end else if (phase_cnt_q == LastPhase) begin
      phase_cnt_q <= '0;
    end else begin
      phase_cnt_q <= phase_cnt_q + 1'b1;
    end
  end

  assign boundary = (phase_cnt_q == LastPhase);

  // Target as it will be after this edge, and the duty step taken toward it.
  always_comb begin
    target_new = (boundary && pending_v) ? pending : target_q;
    duty_next  = ramp_toward(duty_q, target_new, Step);
  end

  // Next-state logic for the scheduler FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant) state_d = StPending;
      end
      StPending: begin
        if (boundary) state_d = (duty_next != target_new) ? StRamping : StIdle;
      end
      StRamping: begin
        if (grant) begin
          state_d = StPending;
        end else if (boundary && (duty_next == target_new)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, target/duty registers and registered busy flag.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      target_q <= RESET_DUTY;
      duty_q   <= RESET_DUTY;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
      if (boundary) begin
        target_q <= target_new;
        duty_q   <= duty_next;
      end
    end
  end

  assign bus.duty_cycle   = duty_q;
  assign bus.period_start = boundary;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed bench: one scheduler with immediate steps, one with a slew of 1.
module tb_pwm_duty_scheduler;

  logic clk_50M;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;

  pwm_duty_scheduler_if bus0 ();
  pwm_duty_scheduler_if bus1 ();

  pwm_duty_scheduler #(
    .RAMP_STEP  (0),
    .RESET_DUTY (4'd0)
  ) dut_step0 (
    .clk_50M (clk_50M),
    .reset   (reset),
    .bus     (bus0.slave)
  );

  pwm_duty_scheduler #(
    .RAMP_STEP  (1),
    .RESET_DUTY (4'd0)
  ) dut_step1 (
    .clk_50M (clk_50M),
    .reset   (reset),
    .bus     (bus1.slave)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  // Cycle N is the interval after the Nth rising edge since reset release.
  always @(posedge clk_50M or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the falling edge inside cycle n.
  task automatic goto(input int n);
    if (cyc > n) check("goto_overrun", cyc, n);
    while (cyc < n) @(negedge clk_50M);
  endtask

  task automatic do_reset();
    @(negedge clk_50M);
    reset = 1'b1;
    repeat (3) @(negedge clk_50M);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    bus0.req_a = 1'b0; bus0.duty_a = '0; bus0.req_b = 1'b0; bus0.duty_b = '0;
    bus1.req_a = 1'b0; bus1.duty_a = '0; bus1.req_b = 1'b0; bus1.duty_b = '0;

    // Reset values and period_start cadence; immediate update of 8.
    do_reset();
    check("rst_duty0", bus0.duty_cycle, 0);
    check("rst_busy0", bus0.busy, 0);
    check("rst_duty1", bus1.duty_cycle, 0);
    check("rst_acks", {bus0.ack_a, bus0.ack_b, bus1.ack_a, bus1.ack_b}, 0);
    check("rst_ps", bus0.period_start, 0);
    goto(10);
    bus0.req_a = 1'b1; bus0.duty_a = 4'd8;
    goto(11);
    check("s0_ack_a_on", bus0.ack_a, 1);
    check("s0_busy_on", bus0.busy, 1);
    bus0.req_a = 1'b0;
    goto(12);
    check("s0_ack_a_off", bus0.ack_a, 0);
    goto(254);
    check("ps_254", bus1.period_start, 0);
    goto(255);
    check("ps_255", bus0.period_start, 1);
    check("s0_duty_255", bus0.duty_cycle, 0);
    goto(256);
    check("ps_256", bus0.period_start, 0);
    check("s0_duty_256", bus0.duty_cycle, 8);
    check("s0_busy_256", bus0.busy, 0);
    goto(511);
    check("ps_511", bus1.period_start, 1);

    // Tie from reset: A wins, B waits for the slot to drain at the boundary.
    do_reset();
    goto(10);
    bus0.req_a = 1'b1; bus0.duty_a = 4'd4;
    bus0.req_b = 1'b1; bus0.duty_b = 4'd12;
    goto(11);
    check("tie_ack_a", bus0.ack_a, 1);
    check("tie_ack_b_wait", bus0.ack_b, 0);
    bus0.req_a = 1'b0;
    goto(12);
    check("tie_ack_a_once", bus0.ack_a, 0);
    goto(255);
    check("tie_ack_b_bnd", bus0.ack_b, 0);
    goto(256);
    check("tie_duty_256", bus0.duty_cycle, 4);
    check("tie_ack_b_defer", bus0.ack_b, 0);
    goto(257);
    check("tie_ack_b_on", bus0.ack_b, 1);
    bus0.req_b = 1'b0;
    goto(258);
    check("tie_ack_b_off", bus0.ack_b, 0);
    goto(512);
    check("tie_duty_512", bus0.duty_cycle, 12);
    check("tie_busy_512", bus0.busy, 0);

    // A alone, then a tie while the slot is full: B goes first this time.
    goto(520);
    bus0.req_a = 1'b1; bus0.duty_a = 4'd3;
    goto(521);
    check("rr_ack_a1", bus0.ack_a, 1);
    bus0.req_a = 1'b0;
    goto(530);
    bus0.req_a = 1'b1; bus0.duty_a = 4'd6;
    bus0.req_b = 1'b1; bus0.duty_b = 4'd9;
    goto(600);
    check("rr_full_acks", {bus0.ack_a, bus0.ack_b}, 0);
    goto(768);
    check("rr_duty_768", bus0.duty_cycle, 3);
    check("rr_acks_768", {bus0.ack_a, bus0.ack_b}, 0);
    goto(769);
    check("rr_ack_b", bus0.ack_b, 1);
    check("rr_ack_a_wait", bus0.ack_a, 0);
    bus0.req_b = 1'b0;
    goto(1024);
    check("rr_duty_1024", bus0.duty_cycle, 9);
    goto(1025);
    check("rr_ack_a2", bus0.ack_a, 1);
    bus0.req_a = 1'b0;
    goto(1280);
    check("rr_duty_1280", bus0.duty_cycle, 6);
    goto(1281);
    check("rr_busy_end", bus0.busy, 0);

    // Slew of 1: 0 -> 11 one step per boundary.
    do_reset();
    goto(10);
    bus1.req_a = 1'b1; bus1.duty_a = 4'd11;
    goto(11);
    check("r1_ack_a", bus1.ack_a, 1);
    bus1.req_a = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      goto(256 * k - 1);
      check("r1_duty_pre", bus1.duty_cycle, k - 1);
      check("r1_busy_pre", bus1.busy, 1);
      goto(256 * k);
      check("r1_duty_post", bus1.duty_cycle, k);
    end
    check("r1_busy_done", bus1.busy, 0);

    // Ramp down 11 -> 5, then up toward 10 and reset mid-ramp.
    goto(2830);
    bus1.req_a = 1'b1; bus1.duty_a = 4'd5;
    goto(2831);
    check("r1_ack_dn", bus1.ack_a, 1);
    bus1.req_a = 1'b0;
    goto(3072);
    check("r1_duty_3072", bus1.duty_cycle, 10);
    goto(4351);
    check("r1_duty_4351", bus1.duty_cycle, 6);
    goto(4352);
    check("r1_duty_4352", bus1.duty_cycle, 5);
    goto(4360);
    bus1.req_a = 1'b1; bus1.duty_a = 4'd10;
    goto(4361);
    bus1.req_a = 1'b0;
    goto(4864);
    check("r1_duty_4864", bus1.duty_cycle, 7);
    check("r1_busy_4864", bus1.busy, 1);
    goto(4900);
    bus1.req_b = 1'b1; bus1.duty_b = 4'd3;
    #5 reset = 1'b1;
    #1;
    check("ar_duty1", bus1.duty_cycle, 0);
    check("ar_busy1", bus1.busy, 0);
    check("ar_acks", {bus1.ack_a, bus1.ack_b}, 0);
    check("ar_duty0", bus0.duty_cycle, 0);
    @(negedge clk_50M);
    @(negedge clk_50M);
    reset = 1'b0;
    check("ar_cyc0_ack_b", bus1.ack_b, 0);
    goto(1);
    check("ar_ack_b", bus1.ack_b, 1);
    bus1.req_b = 1'b0;
    goto(254);
    check("ar_ps_254", bus1.period_start, 0);
    goto(255);
    check("ar_ps_255", bus1.period_start, 1);
    check("ar_duty_255", bus1.duty_cycle, 0);
    goto(256);
    check("ar_duty_256", bus1.duty_cycle, 1);
    check("ar_busy_256", bus1.busy, 1);
    goto(768);
    check("ar_duty_768", bus1.duty_cycle, 3);
    check("ar_busy_768", bus1.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
